// File: rtl/top_receiver.sv
// UART receive path: oversampled 8N1 frame recovery (PHY) feeding a byte/line-feed counting job engine (MAC).
module top_receiver #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic        system_clock,
    input  logic        rst_n,
    input  logic        clock_enable,
    input  logic        start,
    input  logic        rx,
    input  logic [14:0] num_bytes_to_receive,
    input  logic [1:0]  delay,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        framing_error,
    output logic [16:0] data_counter,
    output logic [7:0]  line_counter,
    output logic        busy,
    output logic        done
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        PHY_IDLE,
        PHY_START,
        PHY_DATA,
        PHY_STOP,
        PHY_WAIT_HIGH
    } phy_state_t;

    typedef enum logic {
        MAC_IDLE,
        MAC_RECEIVE
    } mac_state_t;

    phy_state_t        phy_state;
    mac_state_t        mac_state;
    logic              rx_m;
    logic              rx_s;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        bit_cnt;
    logic [1:0]        stop_cnt;
    logic [7:0]        shift;
    logic [14:0]       target;
    logic              stop_sample_c;
    logic              byte_good_c;
    logic [16:0]       next_count_c;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Good byte is decided on the tick of the final stop sample so the MAC can register it directly
    assign stop_sample_c = (phy_state == PHY_STOP) && clock_enable && (tick_cnt == FULL_LAST);
    assign byte_good_c   = stop_sample_c && rx_s && (stop_cnt == delay);
    assign next_count_c  = data_counter + 17'd1;

    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            phy_state     <= PHY_IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            stop_cnt      <= '0;
            shift         <= '0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            if (clock_enable) begin
                case (phy_state)
                    PHY_IDLE: begin
                        if (!rx_s) begin
                            phy_state <= PHY_START;
                            tick_cnt  <= '0;
                        end
                    end
                    PHY_START: begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt  <= '0;
                            bit_cnt   <= '0;
                            phy_state <= rx_s ? PHY_IDLE : PHY_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    PHY_DATA: begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            shift    <= {rx_s, shift[7:1]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                phy_state <= PHY_STOP;
                                stop_cnt  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    PHY_STOP: begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                framing_error <= 1'b1;
                                phy_state     <= PHY_WAIT_HIGH;
                            end else if (stop_cnt == delay) begin
                                phy_state <= PHY_IDLE;
                            end else begin
                                stop_cnt <= stop_cnt + 2'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    PHY_WAIT_HIGH: begin
                        if (rx_s) begin
                            phy_state <= PHY_IDLE;
                        end
                    end
                    default: phy_state <= PHY_IDLE;
                endcase
            end
        end
    end

    // Job engine: bytes are only accepted and counted while a job is armed
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            mac_state    <= MAC_IDLE;
            target       <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            data_counter <= '0;
            line_counter <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            done       <= 1'b0;
            case (mac_state)
                MAC_IDLE: begin
                    if (start && (num_bytes_to_receive != 15'd0)) begin
                        target       <= num_bytes_to_receive;
                        data_counter <= '0;
                        line_counter <= '0;
                        busy         <= 1'b1;
                        mac_state    <= MAC_RECEIVE;
                    end
                end
                MAC_RECEIVE: begin
                    if (byte_good_c) begin
                        data_out     <= shift;
                        data_valid   <= 1'b1;
                        data_counter <= next_count_c;
                        if ((shift == 8'h0A) && (line_counter != 8'hFF)) begin
                            line_counter <= line_counter + 8'd1;
                        end
                        if (next_count_c == {2'b00, target}) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            mac_state <= MAC_IDLE;
                        end
                    end
                end
                default: mac_state <= MAC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_receiver.sv
// Directed bench for top_receiver: serial frames driven bit by bit, strobes tallied by a monitor.
module tb_top_receiver;

    localparam int unsigned OS  = 16;
    localparam int          BIT = 2 * OS;

    logic        system_clock = 1'b0;
    logic        rst_n;
    logic        clock_enable;
    logic        start;
    logic        rx;
    logic [14:0] num;
    logic [1:0]  delay;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        framing_error;
    logic [16:0] data_counter;
    logic [7:0]  line_counter;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int dv_cnt = 0;
    int done_cnt = 0;
    int done_dv_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] rx_q[$];
    int dv0, fe0, done0;

    top_receiver #(.OVERSAMPLE(OS)) dut (
        .system_clock        (system_clock),
        .rst_n               (rst_n),
        .clock_enable        (clock_enable),
        .start               (start),
        .rx                  (rx),
        .num_bytes_to_receive(num),
        .delay               (delay),
        .data_out            (data_out),
        .data_valid          (data_valid),
        .framing_error       (framing_error),
        .data_counter        (data_counter),
        .line_counter        (line_counter),
        .busy                (busy),
        .done                (done)
    );

    always #5 system_clock = ~system_clock;

    // Oversampling tick every other clock
    initial begin
        clock_enable = 1'b0;
        forever begin
            @(negedge system_clock);
            clock_enable = ~clock_enable;
        end
    end

    always @(negedge system_clock) begin
        if (data_valid) begin
            dv_cnt++;
            rx_q.push_back(data_out);
        end
        if (done) begin
            done_cnt++;
            if (data_valid) done_dv_cnt++;
        end
        if (framing_error) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge system_clock);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(BIT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic [3:0] stops, input int nstop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        for (int i = 0; i < nstop; i++) send_bit(stops[i]);
    endtask

    task automatic pulse_start(input logic [14:0] n);
        num   = n;
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'h00);
        check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_framing_error"}, 32'(framing_error), 32'd0);
        check({tag, "_data_counter"}, 32'(data_counter), 32'd0);
        check({tag, "_line_counter"}, 32'(line_counter), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        start = 1'b0;
        num   = '0;
        delay = 2'd0;
        idle(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(4);

        // bytes before any start are dropped; a zero count is ignored
        send_frame(8'h77, 4'b0001, 1);
        idle(BIT);
        check("prearm_dv", 32'(dv_cnt), 32'd0);
        check("prearm_count", 32'(data_counter), 32'd0);
        pulse_start(15'd0);
        idle(1);
        check("zero_start_busy", 32'(busy), 32'd0);

        // basic job of two bytes
        pulse_start(15'd2);
        check("basic_busy_rise", 32'(busy), 32'd1);
        send_frame(8'h41, 4'b0001, 1);
        send_frame(8'h0A, 4'b0001, 1);
        idle(BIT);
        check("basic_dv_cnt", 32'(dv_cnt), 32'd2);
        check("basic_byte0", 32'(rx_q[0]), 32'h41);
        check("basic_byte1", 32'(rx_q[1]), 32'h0A);
        check("basic_data_counter", 32'(data_counter), 32'd2);
        check("basic_line_counter", 32'(line_counter), 32'd1);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        check("basic_done_with_dv", 32'(done_dv_cnt), 32'd1);
        check("basic_busy_fall", 32'(busy), 32'd0);

        // short low glitch is rejected, following frame still decoded
        pulse_start(15'd1);
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        rx = 1'b0;
        idle(8);
        rx = 1'b1;
        idle(2 * BIT);
        check("glitch_dv", 32'(dv_cnt), 32'(dv0));
        check("glitch_fe", 32'(fe_cnt), 32'(fe0));
        check("glitch_busy", 32'(busy), 32'd1);
        send_frame(8'h5A, 4'b0001, 1);
        idle(BIT);
        check("glitch_next_dv", 32'(dv_cnt), 32'(dv0 + 1));
        check("glitch_next_byte", 32'(data_out), 32'h5A);
        check("glitch_next_done", 32'(done_cnt), 32'd2);
        check("glitch_line_cleared", 32'(line_counter), 32'd0);

        // low stop bit followed by a long break
        pulse_start(15'd1);
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h55, 4'b0000, 1);
        idle(20 * BIT);
        rx = 1'b1;
        idle(2 * BIT);
        check("ferr_fe_cnt", 32'(fe_cnt), 32'(fe0 + 1));
        check("ferr_dv", 32'(dv_cnt), 32'(dv0));
        check("ferr_count", 32'(data_counter), 32'd0);
        check("ferr_busy", 32'(busy), 32'd1);
        send_frame(8'h33, 4'b0001, 1);
        idle(BIT);
        check("ferr_next_byte", 32'(data_out), 32'h33);
        check("ferr_next_count", 32'(data_counter), 32'd1);
        check("ferr_next_done", 32'(done_cnt), 32'd3);

        // two stop bits: second one low, then a clean frame
        delay = 2'd1;
        pulse_start(15'd1);
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'hC3, 4'b0001, 2);
        rx = 1'b1;
        idle(2 * BIT);
        check("stop2_fe_cnt", 32'(fe_cnt), 32'(fe0 + 1));
        check("stop2_dv", 32'(dv_cnt), 32'(dv0));
        send_frame(8'hC3, 4'b0011, 2);
        idle(BIT);
        check("stop2_good_dv", 32'(dv_cnt), 32'(dv0 + 1));
        check("stop2_good_byte", 32'(data_out), 32'hC3);
        check("stop2_done", 32'(done_cnt), 32'd4);
        delay = 2'd0;

        // start during a job must not reload the count
        pulse_start(15'd3);
        done0 = done_cnt;
        fork
            send_frame(8'h01, 4'b0001, 1);
            begin
                idle(100);
                pulse_start(15'd1);
            end
        join
        send_frame(8'h02, 4'b0001, 1);
        idle(BIT);
        check("ign_busy_mid", 32'(busy), 32'd1);
        check("ign_done_mid", 32'(done_cnt), 32'(done0));
        check("ign_count_mid", 32'(data_counter), 32'd2);
        send_frame(8'h03, 4'b0001, 1);
        idle(BIT);
        check("ign_count_end", 32'(data_counter), 32'd3);
        check("ign_done_end", 32'(done_cnt), 32'(done0 + 1));
        check("ign_busy_end", 32'(busy), 32'd0);
        check("ign_byte", 32'(data_out), 32'h03);

        // reset in the middle of the data bits
        pulse_start(15'd2);
        dv0 = dv_cnt;
        done0 = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(BIT / 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        rx = 1'b1;
        idle(BIT);
        rst_n = 1'b1;
        idle(2 * BIT);
        check("midreset_no_dv", 32'(dv_cnt), 32'(dv0));
        check("midreset_no_done", 32'(done_cnt), 32'(done0));
        pulse_start(15'd1);
        send_frame(8'hFF, 4'b0001, 1);
        idle(BIT);
        check("postreset_count", 32'(data_counter), 32'd1);
        check("postreset_done", 32'(done_cnt), 32'(done0 + 1));
        check("postreset_byte", 32'(data_out), 32'hFF);
        check("postreset_busy", 32'(busy), 32'd0);
        check("all_done_with_dv", 32'(done_dv_cnt), 32'(done_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
